// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: arbitrates memory-wait,
// taken-branch and load-use hazards, and keeps a watchdog and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int WAIT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam bit              WDOG_EN     = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] TIMEOUT_LIM = WAIT_W'(MEM_TIMEOUT);

    state_t            state_q;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              mem_hz;
    logic              lu_hz;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v,
                                                     input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
        if (v != {WAIT_W{1'b1}}) begin
            return v + WAIT_W'(1);
        end
        return v;
    endfunction

    assign mem_hz = (exmem_memread | exmem_memwrite) & ~dmem_ready;
    // x0 is hardwired zero, so a load targeting it can never create a dependency.
    assign lu_hz  = idex_memread & (idex_rd != 5'd0) &
                    ((idex_rd == id_rs1) | (idex_rd == id_rs2));

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (mem_hz) begin
            // Whole front freezes; a pending branch stays in EX and re-asserts on release.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu_hz) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        state_nxt = RUN;
        if (mem_hz) begin
            state_nxt = MEM_WAIT;
        end else if (lu_hz && !branch_taken) begin
            state_nxt = LU_STALL;
        end
    end

    assign wait_inc = sat_inc_wait(wait_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state_q      <= state_nxt;
            wait_cnt     <= mem_hz ? wait_inc : '0;
            // Sticky until reset; stalling itself continues regardless.
            if (WDOG_EN && mem_hz && (wait_inc >= TIMEOUT_LIM)) begin
                mem_timeout <= 1'b1;
            end
            stall_cycles <= sat_inc_cnt(stall_cycles, ~pc_write);
            flush_count  <= sat_inc_cnt(flush_count, ifid_flush);
        end
    end

    assign state = state_q;

endmodule
